// File: rtl/add_multicycle_stager_if.sv
// Handshake and adder-side signal bundle for add_multicycle_stager.
// slave: the stager itself. master: upstream, downstream and adder side.
interface add_multicycle_stager_if #(
    parameter int unsigned WIDTH     = 45,
    parameter int unsigned CNT_WIDTH = 16
);
    logic                 i_valid;
    logic                 o_ready;
    logic [WIDTH-1:0]     i_term1;
    logic [WIDTH-1:0]     i_term2;
    logic [WIDTH-1:0]     o_add_term1;
    logic [WIDTH-1:0]     o_add_term2;
    logic [WIDTH:0]       i_add_result;
    logic                 o_valid;
    logic                 i_ready;
    logic [WIDTH:0]       o_result;
    logic                 o_carry;
    logic [CNT_WIDTH-1:0] o_done_count;

    modport slave (
        input  i_valid,
        input  i_term1,
        input  i_term2,
        input  i_add_result,
        input  i_ready,
        output o_ready,
        output o_add_term1,
        output o_add_term2,
        output o_valid,
        output o_result,
        output o_carry,
        output o_done_count
    );

    modport master (
        output i_valid,
        output i_term1,
        output i_term2,
        output i_add_result,
        output i_ready,
        input  o_ready,
        input  o_add_term1,
        input  o_add_term2,
        input  o_valid,
        input  o_result,
        input  o_carry,
        input  o_done_count
    );
endinterface

// File: rtl/add_multicycle_stager.sv
// Sequencer around an external ripple-carry adder: launches an operand pair, waits a
// fixed settle window for the carry chain, captures the sum and hands it downstream.
module add_multicycle_stager #(
    parameter int unsigned WIDTH         = 45,
    parameter int unsigned SETTLE_CYCLES = 3,
    parameter int unsigned CNT_WIDTH     = 16
) (
    input logic                    i_clk,
    input logic                    i_rst_n,
    add_multicycle_stager_if.slave stg_io
);

    localparam int unsigned SettleW = 4;

    if (SETTLE_CYCLES < 1 || SETTLE_CYCLES > 15) begin : gen_bad_settle
        $error("add_multicycle_stager: SETTLE_CYCLES must be in 1..15");
    end

    typedef enum logic [1:0] {StIdle, StSettle, StHold} state_e;

    state_e               state_q, state_d;
    logic [SettleW-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]     term1_q, term1_d;
    logic [WIDTH-1:0]     term2_q, term2_d;
    logic [WIDTH:0]       result_q, result_d;
    logic                 valid_q, valid_d;
    logic [CNT_WIDTH-1:0] done_q, done_d;
    logic                 ready;
    logic                 accept;

    // Next-state logic: launch, settle countdown, capture, and handoff/overlap.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        term1_d  = term1_q;
        term2_d  = term2_q;
        result_d = result_q;
        valid_d  = valid_q;
        done_d   = done_q;

        // Ready depends combinationally on downstream ready while holding a result.
        ready  = (state_q == StIdle) || ((state_q == StHold) && stg_io.i_ready);
        accept = stg_io.i_valid && ready;

        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    term1_d = stg_io.i_term1;
                    term2_d = stg_io.i_term2;
                    cnt_d   = SettleW'(SETTLE_CYCLES - 1);
                    state_d = StSettle;
                end
            end
            StSettle: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - 1'b1;
                end else begin
                    // Carry chain has had its full window; sample the sum exactly once.
                    result_d = stg_io.i_add_result;
                    valid_d  = 1'b1;
                    state_d  = StHold;
                end
            end
            StHold: begin
                if (stg_io.i_ready) begin
                    done_d  = done_q + CNT_WIDTH'(1);
                    valid_d = 1'b0;
                    if (stg_io.i_valid) begin
                        term1_d = stg_io.i_term1;
                        term2_d = stg_io.i_term2;
                        cnt_d   = SettleW'(SETTLE_CYCLES - 1);
                        state_d = StSettle;
                    end else begin
                        state_d = StIdle;
                    end
                end
            end
            default: begin
                state_d = StIdle;
                valid_d = 1'b0;
            end
        endcase
    end

    // State register; reset aborts any in-flight transaction.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q  <= StIdle;
            cnt_q    <= '0;
            term1_q  <= '0;
            term2_q  <= '0;
            result_q <= '0;
            valid_q  <= 1'b0;
            done_q   <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            term1_q  <= term1_d;
            term2_q  <= term2_d;
            result_q <= result_d;
            valid_q  <= valid_d;
            done_q   <= done_d;
        end
    end

    assign stg_io.o_ready      = ready;
    assign stg_io.o_add_term1  = term1_q;
    assign stg_io.o_add_term2  = term2_q;
    assign stg_io.o_valid      = valid_q;
    assign stg_io.o_result     = result_q;
    assign stg_io.o_carry      = result_q[WIDTH];
    assign stg_io.o_done_count = done_q;

endmodule
